// File: rtl/mips_pipe_pkg.sv
// Types and widths shared by the MIPS pipeline stages.
// The memory-stage state encoding lives here so neighbouring stages and debug logic agree on it.
package mips_pipe_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;

    typedef enum logic {
        MEM_IDLE   = 1'b0,
        MEM_ACCESS = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_watchdog.sv
// Access watchdog: counts cycles while enabled and flags the last allowed cycle.
// The count holds once the flag is raised, so it can never wrap.
module mem_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expired = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: EXE/MEM register, data-memory request/ack handshake with timeout,
// and the registered MEM/WB word presented to write-back.
module mem_stage
    import mips_pipe_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              evalid,
    input  logic              wregin,
    input  logic              m2regin,
    input  logic              wmemin,
    input  logic [REG_W-1:0]  RdRtin,
    input  logic [DATA_W-1:0] qbin,
    input  logic [DATA_W-1:0] aluin,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              mvalid,
    output logic              mwreg,
    output logic              mm2reg,
    output logic [REG_W-1:0]  mRdRt,
    output logic [DATA_W-1:0] malu,
    output logic [DATA_W-1:0] mmo,
    output logic              merr
);

    mem_state_e        state_q;
    logic              req_q, we_q;
    logic [DATA_W-1:0] addr_q, wdata_q;
    logic              wreg_q;
    logic [REG_W-1:0]  rd_q;
    logic              mvalid_q, mwreg_q, mm2reg_q, merr_q;
    logic [REG_W-1:0]  mrd_q;
    logic [DATA_W-1:0] malu_q, mmo_q;
    logic              wd_expired;

    mem_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (state_q == MEM_IDLE),
        .en     ((state_q == MEM_ACCESS) && !dmem_ack),
        .expired(wd_expired)
    );

    assign stall      = (state_q == MEM_ACCESS);
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign mvalid     = mvalid_q;
    assign mwreg      = mwreg_q;
    assign mm2reg     = mm2reg_q;
    assign mRdRt      = mrd_q;
    assign malu       = malu_q;
    assign mmo        = mmo_q;
    assign merr       = merr_q;

    // The access address doubles as the captured ALU result; a store wins when both
    // m2regin and wmemin are set, so a load is simply "access with we_q low".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= MEM_IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wreg_q   <= 1'b0;
            rd_q     <= '0;
            mvalid_q <= 1'b0;
            mwreg_q  <= 1'b0;
            mm2reg_q <= 1'b0;
            merr_q   <= 1'b0;
            mrd_q    <= '0;
            malu_q   <= '0;
            mmo_q    <= '0;
        end else begin
            mvalid_q <= 1'b0;
            case (state_q)
                MEM_IDLE: begin
                    if (evalid) begin
                        if (!m2regin && !wmemin) begin
                            mvalid_q <= 1'b1;
                            mwreg_q  <= wregin;
                            mm2reg_q <= 1'b0;
                            mrd_q    <= RdRtin;
                            malu_q   <= aluin;
                            mmo_q    <= '0;
                            merr_q   <= 1'b0;
                        end else if (aluin[1:0] != 2'b00) begin
                            mvalid_q <= 1'b1;
                            mwreg_q  <= 1'b0;
                            mm2reg_q <= 1'b0;
                            mrd_q    <= RdRtin;
                            malu_q   <= aluin;
                            mmo_q    <= '0;
                            merr_q   <= 1'b1;
                        end else begin
                            state_q <= MEM_ACCESS;
                            req_q   <= 1'b1;
                            we_q    <= wmemin;
                            addr_q  <= aluin;
                            wdata_q <= qbin;
                            wreg_q  <= wregin;
                            rd_q    <= RdRtin;
                        end
                    end
                end
                MEM_ACCESS: begin
                    if (dmem_ack) begin
                        state_q  <= MEM_IDLE;
                        req_q    <= 1'b0;
                        mvalid_q <= 1'b1;
                        mwreg_q  <= wreg_q;
                        mm2reg_q <= !we_q;
                        mrd_q    <= rd_q;
                        malu_q   <= addr_q;
                        mmo_q    <= we_q ? '0 : dmem_rdata;
                        merr_q   <= 1'b0;
                    end else if (wd_expired) begin
                        state_q  <= MEM_IDLE;
                        req_q    <= 1'b0;
                        mvalid_q <= 1'b1;
                        mwreg_q  <= 1'b0;
                        mm2reg_q <= 1'b0;
                        mrd_q    <= rd_q;
                        malu_q   <= addr_q;
                        mmo_q    <= '0;
                        merr_q   <= 1'b1;
                    end
                end
                default: state_q <= MEM_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: table of single-cycle words plus
// hand-written load/store/timeout/reset sequences.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        evalid = 1'b0, wregin = 1'b0, m2regin = 1'b0, wmemin = 1'b0;
    logic [4:0]  RdRtin = '0;
    logic [31:0] qbin = '0, aluin = '0;
    logic        stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        mvalid, mwreg, mm2reg, merr;
    logic [4:0]  mRdRt;
    logic [31:0] malu, mmo;

    int checks = 0;
    int errors = 0;

    mem_stage #(
        .TIMEOUT(4)
    ) dut (
        .clk(clk), .rst(rst), .evalid(evalid), .wregin(wregin), .m2regin(m2regin),
        .wmemin(wmemin), .RdRtin(RdRtin), .qbin(qbin), .aluin(aluin), .stall(stall),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .mvalid(mvalid), .mwreg(mwreg), .mm2reg(mm2reg), .mRdRt(mRdRt),
        .malu(malu), .mmo(mmo), .merr(merr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ev, wr, m2, wm;
        logic [4:0]  rd;
        logic [31:0] qb, alu;
        logic        xv, xwr, xm2;
        logic [4:0]  xrd;
        logic [31:0] xalu, xmmo;
        logic        xerr;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic ev, input logic wr, input logic m2, input logic wm,
                         input logic [4:0] rd, input logic [31:0] qb, input logic [31:0] alu);
        evalid = ev; wregin = wr; m2regin = m2; wmemin = wm;
        RdRtin = rd; qbin = qb; aluin = alu;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    int reqcyc;

    initial begin
        tbl[0] = '{1,1,0,0, 5'd5,  32'h0,     32'h0000_002A, 1,1,0, 5'd5,  32'h0000_002A, 32'h0, 0};
        tbl[1] = '{0,0,0,0, 5'd9,  32'h0,     32'h0000_0033, 0,1,0, 5'd5,  32'h0000_002A, 32'h0, 0};
        tbl[2] = '{1,0,0,0, 5'd31, 32'h0,     32'hFFFF_FFFF, 1,0,0, 5'd31, 32'hFFFF_FFFF, 32'h0, 0};
        tbl[3] = '{1,1,1,0, 5'd6,  32'h0,     32'h0000_0102, 1,0,0, 5'd6,  32'h0000_0102, 32'h0, 1};
        tbl[4] = '{0,1,0,0, 5'd8,  32'h0,     32'h0000_0050, 0,0,0, 5'd6,  32'h0000_0102, 32'h0, 1};
        tbl[5] = '{1,0,0,1, 5'd0,  32'hBEEF,  32'h0000_0203, 1,0,0, 5'd0,  32'h0000_0203, 32'h0, 1};
        tbl[6] = '{1,1,0,0, 5'd12, 32'h0,     32'h0000_1000, 1,1,0, 5'd12, 32'h0000_1000, 32'h0, 0};

        // Reset state
        #12;
        chk("rst_mvalid", {31'b0, mvalid}, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_req", {31'b0, dmem_req}, 32'd0);
        chk("rst_malu", malu, 32'd0);
        chk("rst_merr", {31'b0, merr}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single-cycle words: ALU ops, idle cycles and misaligned accesses
        for (int unsigned i = 0; i < 7; i++) begin
            @(negedge clk);
            drive(tbl[i].ev, tbl[i].wr, tbl[i].m2, tbl[i].wm, tbl[i].rd, tbl[i].qb, tbl[i].alu);
            step();
            chk($sformatf("v%0d_mvalid", i), {31'b0, mvalid}, {31'b0, tbl[i].xv});
            chk($sformatf("v%0d_mwreg", i), {31'b0, mwreg}, {31'b0, tbl[i].xwr});
            chk($sformatf("v%0d_mm2reg", i), {31'b0, mm2reg}, {31'b0, tbl[i].xm2});
            chk($sformatf("v%0d_mRdRt", i), {27'b0, mRdRt}, {27'b0, tbl[i].xrd});
            chk($sformatf("v%0d_malu", i), malu, tbl[i].xalu);
            chk($sformatf("v%0d_mmo", i), mmo, tbl[i].xmmo);
            chk($sformatf("v%0d_merr", i), {31'b0, merr}, {31'b0, tbl[i].xerr});
            chk($sformatf("v%0d_req", i), {31'b0, dmem_req}, 32'd0);
            chk($sformatf("v%0d_stall", i), {31'b0, stall}, 32'd0);
        end

        // Load acknowledged on the third edge after acceptance
        @(negedge clk);
        drive(1, 1, 1, 0, 5'd9, 32'h0, 32'h0000_0100);
        step();
        chk("ld_req", {31'b0, dmem_req}, 32'd1);
        chk("ld_we", {31'b0, dmem_we}, 32'd0);
        chk("ld_addr", dmem_addr, 32'h0000_0100);
        chk("ld_mvalid0", {31'b0, mvalid}, 32'd0);
        @(negedge clk);
        drive(1, 0, 0, 0, 5'd1, 32'h0, 32'h0000_0FF0);
        reqcyc = 0;
        for (int unsigned c = 0; c < 2; c++) begin
            if (stall) reqcyc++;
            step();
        end
        if (stall) reqcyc++;
        chk("ld_addr_held", dmem_addr, 32'h0000_0100);
        @(negedge clk);
        dmem_ack = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        step();
        chk("ld_stall_cycles", reqcyc, 32'd3);
        chk("ld_mvalid", {31'b0, mvalid}, 32'd1);
        chk("ld_mmo", mmo, 32'hDEAD_BEEF);
        chk("ld_mm2reg", {31'b0, mm2reg}, 32'd1);
        chk("ld_mwreg", {31'b0, mwreg}, 32'd1);
        chk("ld_mRdRt", {27'b0, mRdRt}, 32'd9);
        chk("ld_malu", malu, 32'h0000_0100);
        chk("ld_stall_end", {31'b0, stall}, 32'd0);
        chk("ld_req_end", {31'b0, dmem_req}, 32'd0);
        @(negedge clk);
        dmem_ack = 1'b0;
        drive(0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        step();

        // Store acked next cycle, then an ALU word with no bubble
        @(negedge clk);
        drive(1, 0, 0, 1, 5'd3, 32'h0000_1234, 32'h0000_0204);
        step();
        chk("st_req", {31'b0, dmem_req}, 32'd1);
        chk("st_we", {31'b0, dmem_we}, 32'd1);
        chk("st_wdata", dmem_wdata, 32'h0000_1234);
        chk("st_addr", dmem_addr, 32'h0000_0204);
        chk("st_stall", {31'b0, stall}, 32'd1);
        @(negedge clk);
        dmem_ack = 1'b1;
        dmem_rdata = 32'h5555_AAAA;
        drive(1, 1, 0, 0, 5'd7, 32'h0, 32'h0000_0055);
        step();
        chk("st_mvalid", {31'b0, mvalid}, 32'd1);
        chk("st_mwreg", {31'b0, mwreg}, 32'd0);
        chk("st_merr", {31'b0, merr}, 32'd0);
        chk("st_mmo", mmo, 32'd0);
        chk("st_mm2reg", {31'b0, mm2reg}, 32'd0);
        chk("st_req_end", {31'b0, dmem_req}, 32'd0);
        @(negedge clk);
        dmem_ack = 1'b0;
        step();
        chk("b2b_mvalid", {31'b0, mvalid}, 32'd1);
        chk("b2b_malu", malu, 32'h0000_0055);
        chk("b2b_mRdRt", {27'b0, mRdRt}, 32'd7);
        chk("b2b_mwreg", {31'b0, mwreg}, 32'd1);

        // m2regin and wmemin together behave as a store
        @(negedge clk);
        drive(1, 0, 1, 1, 5'd2, 32'h0000_00AA, 32'h0000_0300);
        step();
        chk("both_we", {31'b0, dmem_we}, 32'd1);
        @(negedge clk);
        drive(0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        dmem_ack = 1'b1;
        dmem_rdata = 32'h0000_FFFF;
        step();
        chk("both_mm2reg", {31'b0, mm2reg}, 32'd0);
        chk("both_mmo", mmo, 32'd0);
        chk("both_mvalid", {31'b0, mvalid}, 32'd1);
        @(negedge clk);
        dmem_ack = 1'b0;

        // Timeout: no acknowledge, request held for TIMEOUT cycles
        drive(1, 1, 1, 0, 5'd4, 32'h0, 32'h0000_0400);
        step();
        @(negedge clk);
        drive(0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        #1;
        reqcyc = 0;
        for (int unsigned c = 0; c < 10; c++) begin
            if (!dmem_req) break;
            reqcyc++;
            step();
        end
        chk("to_req_cycles", reqcyc, 32'd4);
        chk("to_mvalid", {31'b0, mvalid}, 32'd1);
        chk("to_merr", {31'b0, merr}, 32'd1);
        chk("to_mwreg", {31'b0, mwreg}, 32'd0);
        chk("to_malu", malu, 32'h0000_0400);
        chk("to_stall", {31'b0, stall}, 32'd0);
        step();
        @(negedge clk);
        dmem_ack = 1'b1;
        dmem_rdata = 32'h1111_1111;
        step();
        chk("late_mvalid", {31'b0, mvalid}, 32'd0);
        chk("late_req", {31'b0, dmem_req}, 32'd0);
        chk("late_stall", {31'b0, stall}, 32'd0);
        chk("late_mmo", mmo, 32'd0);
        @(negedge clk);
        dmem_ack = 1'b0;

        // Asynchronous reset in the middle of an access
        drive(1, 1, 1, 0, 5'd10, 32'h0, 32'h0000_0500);
        step();
        @(negedge clk);
        drive(0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        step();
        chk("mid_stall", {31'b0, stall}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid_req", {31'b0, dmem_req}, 32'd0);
        chk("rstmid_stall", {31'b0, stall}, 32'd0);
        chk("rstmid_mvalid", {31'b0, mvalid}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(1, 1, 0, 0, 5'd2, 32'h0, 32'h0000_0077);
        step();
        chk("post_mvalid", {31'b0, mvalid}, 32'd1);
        chk("post_malu", malu, 32'h0000_0077);
        chk("post_mRdRt", {27'b0, mRdRt}, 32'd2);
        chk("post_req", {31'b0, dmem_req}, 32'd0);
        @(negedge clk);
        drive(0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the five-stage MIPS datapath: receiver of the EXE stage's outputs. Registers the EXE/MEM pipeline word, performs the data-memory load or store over a request/acknowledge bus, stalls upstream while the access is outstanding, and presents the MEM/WB word (write-back controls, destination register, ALU result, memory data) to WB. Sits between EXE and WB; the data memory is an external responder with variable latency.

## Interface
Parameters:
- TIMEOUT, 255: maximum cycles a request may wait for acknowledge before abort; legal range 1..1023.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- evalid  in  1  EXE word valid this cycle.
- wregin  in  1  register write-back enable from EXE.
- m2regin  in  1  load: write-back data comes from memory.
- wmemin  in  1  store enable.
- RdRtin  in  5  destination register number.
- qbin  in  32  store data (rt operand).
- aluin  in  32  ALU result / effective address.
- stall  out  1  EXE word not accepted; upstream must hold all inputs.
- dmem_req  out  1  data-memory request.
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req.
- dmem_addr  out  32  byte address, word-aligned.
- dmem_wdata  out  32  store data.
- dmem_ack  in  1  responder completes the request this cycle.
- dmem_rdata  in  32  load data, valid with dmem_ack.
- mvalid  out  1  MEM/WB word valid; one-cycle pulse per accepted EXE word.
- mwreg  out  1  write-back enable to WB.
- mm2reg  out  1  select memory data in WB.
- mRdRt  out  5  destination register.
- malu  out  32  ALU result.
- mmo  out  32  memory read data (0 for non-loads).
- merr  out  1  access fault (misaligned or timeout), pulses with mvalid.

## Operation
- States: IDLE, ACCESS. Reset -> IDLE; every output 0; counter 0.
- IDLE, evalid=0: mvalid=0, outputs otherwise hold.
- IDLE, evalid=1, m2regin=0 and wmemin=0: next edge loads mwreg, mm2reg=0, mRdRt, malu, mmo=0, merr=0, mvalid=1; stay IDLE.
- IDLE, evalid=1, memory op, aluin[1:0]!=0: no request; next edge mvalid=1, merr=1, mwreg=0, malu=aluin, mmo=0.
- IDLE, evalid=1, memory op, aligned: next edge capture word, go ACCESS, dmem_req=1, dmem_we=wmemin, dmem_addr=aluin, dmem_wdata=qbin, counter=0.
- m2regin and wmemin both 1: treated as store; mm2reg forced 0.
- ACCESS, dmem_ack=0: dmem_req/addr/we/wdata held; counter increments.
- ACCESS, dmem_ack=1: next edge dmem_req=0, mvalid=1, mmo=dmem_rdata for loads else 0, merr=0, -> IDLE.
- ACCESS, counter reaches TIMEOUT-1 with dmem_ack=0: next edge abort: dmem_req=0, mvalid=1, merr=1, mwreg=0, -> IDLE.
- dmem_ack while dmem_req=0 (late ack after abort): ignored.
- stall = (state==ACCESS), combinational from state; inputs ignored while stall=1.
- Counter width ceil(log2(TIMEOUT+1)); never wraps, saturates at abort.

## Timing
- Non-memory word: accepted at edge T, mvalid high T..T+1 (1-cycle latency).
- Memory word: accepted edge T; dmem_req high from T; ack sampled at edge T+k (k>=1); mvalid and stall=0 after T+k; latency k+1 cycles.
- Back-to-back: next EXE word accepted at the edge following the completion edge; no extra bubble beyond stall cycles.
- Reset mid-ACCESS: dmem_req, stall, mvalid drop immediately (asynchronous); outstanding access discarded.

## Structure
- Shared package mips_pipe_pkg: DATA_W=32, REG_W=5, mem-stage state enum (MEM_IDLE, MEM_ACCESS); shared with other pipeline stages.
- One sub-module: mem_watchdog (cycle counter with clear, enable, expired flag at TIMEOUT-1).
- Pipeline register and FSM stay in mem_stage.

## Test plan
- ALU op: evalid=1, wregin=1, RdRtin=5, aluin=0x0000_002A -> next cycle mvalid=1, mwreg=1, mRdRt=5, malu=0x2A, mmo=0, no dmem_req.
- Load, 3-cycle ack: m2regin=1, aluin=0x100, dmem_rdata=0xDEADBEEF on ack -> stall high 3 cycles, dmem_addr=0x100, dmem_we=0, then mvalid=1, mmo=0xDEADBEEF, mm2reg=1.
- Store with ack next cycle: wmemin=1, aluin=0x204, qbin=0x1234 -> dmem_we=1, dmem_wdata=0x1234 for 1 cycle, mvalid=1, mwreg=0, merr=0; then immediate ALU word accepted without bubble.
- Misaligned load aluin=0x102 -> no dmem_req, mvalid=1, merr=1, mwreg=0.
- Timeout, TIMEOUT=4, ack never: dmem_req high exactly 4 cycles, then mvalid=1, merr=1; ack pulsed 2 cycles later ignored.
- rst asserted mid-ACCESS -> dmem_req, stall, mvalid 0 same cycle; after release, ALU word completes normally.
